// File: rtl/polaris_bus_pkg.sv
// Shared types and constants for the PolarisCPU I/D bus arbiter.
package polaris_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGntI,
        StGntD,
        StAbort
    } arb_state_e;

    typedef enum logic {
        PortI = 1'b0,
        PortD = 1'b1
    } port_e;

    localparam logic [1:0] SIZ_BYTE  = 2'd0;
    localparam logic [1:0] SIZ_HALF  = 2'd1;
    localparam logic [1:0] SIZ_WORD  = 2'd2;
    localparam logic [1:0] SIZ_DWORD = 2'd3;

    localparam logic [31:0] ABORT_IDAT = 32'hFFFF_FFFF;
    localparam logic [63:0] ABORT_DDAT = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/bus_watchdog.sv
// Saturating bus-cycle watchdog; expired_o flags a strobe held TIMEOUT cycles without ack.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);
    import polaris_bus_pkg::*;

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            cnt_q <= '0;
        end else if (run_i && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // A zero limit disables the watchdog entirely.
    assign expired_o = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/polaris_bus_arbiter.sv
// Round-robin arbiter sharing one 64-bit bus between the CPU instruction and data ports.
module polaris_bus_arbiter
    import polaris_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] iadr_i,
    input  logic        istb_i,
    output logic        iack_o,
    output logic [31:0] idat_o,
    input  logic [63:0] dadr_i,
    input  logic        dstb_i,
    input  logic        dwe_i,
    input  logic [1:0]  dsiz_i,
    input  logic [63:0] ddat_i,
    output logic        dack_o,
    output logic [63:0] ddat_o,
    output logic [63:0] xadr_o,
    output logic        xstb_o,
    output logic        xwe_o,
    output logic [1:0]  xsiz_o,
    output logic [63:0] xdat_o,
    input  logic        xack_i,
    input  logic [63:0] xdat_i,
    output logic        berr_o
);

    arb_state_e state_q;
    port_e      last_q;
    port_e      owner_q;
    logic       in_gnt;
    logic       expired;

    assign in_gnt = (state_q == StGntI) || (state_q == StGntD);

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (state_q == StIdle),
        .run_i     (in_gnt && !xack_i),
        .expired_o (expired)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            last_q  <= PortD;
            owner_q <= PortI;
            xadr_o  <= '0;
            xstb_o  <= 1'b0;
            xwe_o   <= 1'b0;
            xsiz_o  <= SIZ_BYTE;
            xdat_o  <= '0;
            berr_o  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    berr_o <= 1'b0;
                    // On a tie the port that did not go last wins.
                    if (istb_i && (!dstb_i || (last_q == PortD))) begin
                        state_q <= StGntI;
                        owner_q <= PortI;
                        xadr_o  <= iadr_i;
                        xstb_o  <= 1'b1;
                        xwe_o   <= 1'b0;
                        xsiz_o  <= SIZ_WORD;
                        xdat_o  <= '0;
                    end else if (dstb_i) begin
                        state_q <= StGntD;
                        owner_q <= PortD;
                        xadr_o  <= dadr_i;
                        xstb_o  <= 1'b1;
                        xwe_o   <= dwe_i;
                        xsiz_o  <= dsiz_i;
                        xdat_o  <= ddat_i;
                    end
                end
                StGntI, StGntD: begin
                    // A same-cycle ack beats the watchdog.
                    if (xack_i) begin
                        xstb_o  <= 1'b0;
                        last_q  <= owner_q;
                        state_q <= StIdle;
                    end else if (expired) begin
                        xstb_o  <= 1'b0;
                        berr_o  <= 1'b1;
                        state_q <= StAbort;
                    end
                end
                StAbort: begin
                    berr_o  <= 1'b0;
                    last_q  <= owner_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign iack_o = ((state_q == StGntI) && xack_i) ||
                    ((state_q == StAbort) && (owner_q == PortI));
    assign dack_o = ((state_q == StGntD) && xack_i) ||
                    ((state_q == StAbort) && (owner_q == PortD));
    assign idat_o = (state_q == StAbort) ? ABORT_IDAT : xdat_i[31:0];
    assign ddat_o = (state_q == StAbort) ? ABORT_DDAT : xdat_i;

endmodule

// File: tb/tb_polaris_bus_arbiter.sv
// Directed bench for polaris_bus_arbiter: vector table plus multi-cycle corner sequences.
module tb_polaris_bus_arbiter;

    localparam int unsigned TMO = 4;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    localparam logic [63:0] Z64 = 64'h0;
    localparam logic [63:0] A_I = 64'h1000;
    localparam logic [63:0] A_D = 64'h2008;
    localparam logic [63:0] A_R = 64'h30;
    localparam logic [63:0] W41 = 64'h4141_4141_4141_4141;

    logic        clk;
    logic        reset_i;
    logic [63:0] iadr_i;
    logic        istb_i;
    logic        iack_o;
    logic [31:0] idat_o;
    logic [63:0] dadr_i;
    logic        dstb_i;
    logic        dwe_i;
    logic [1:0]  dsiz_i;
    logic [63:0] ddat_i;
    logic        dack_o;
    logic [63:0] ddat_o;
    logic [63:0] xadr_o;
    logic        xstb_o;
    logic        xwe_o;
    logic [1:0]  xsiz_o;
    logic [63:0] xdat_o;
    logic        xack_i;
    logic [63:0] xdat_i;
    logic        berr_o;

    int n_checks = 0;
    int n_fail   = 0;

    polaris_bus_arbiter #(
        .TIMEOUT (TMO)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .iadr_i  (iadr_i),
        .istb_i  (istb_i),
        .iack_o  (iack_o),
        .idat_o  (idat_o),
        .dadr_i  (dadr_i),
        .dstb_i  (dstb_i),
        .dwe_i   (dwe_i),
        .dsiz_i  (dsiz_i),
        .ddat_i  (ddat_i),
        .dack_o  (dack_o),
        .ddat_o  (ddat_o),
        .xadr_o  (xadr_o),
        .xstb_o  (xstb_o),
        .xwe_o   (xwe_o),
        .xsiz_o  (xsiz_o),
        .xdat_o  (xdat_o),
        .xack_i  (xack_i),
        .xdat_i  (xdat_i),
        .berr_o  (berr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        istb;
        logic        dstb;
        logic        dwe;
        logic [1:0]  dsiz;
        logic [63:0] iadr;
        logic [63:0] dadr;
        logic [63:0] ddat;
        logic        xack;
        logic [63:0] xdat;
        logic        e_xstb;
        logic        chk_x;
        logic [63:0] e_xadr;
        logic        e_xwe;
        logic [1:0]  e_xsiz;
        logic [63:0] e_xdat;
        logic        e_iack;
        logic        e_dack;
    } vec_t;

    vec_t vec[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        istb_i = 1'b0;
        iadr_i = '0;
        dstb_i = 1'b0;
        dwe_i  = 1'b0;
        dsiz_i = 2'd0;
        dadr_i = '0;
        ddat_i = '0;
        xack_i = 1'b0;
        xdat_i = '0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        idle_inputs();
        step();
        step();
        reset_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".xstb"}, 64'(xstb_o), Z64);
        check({tag, ".xadr"}, xadr_o, Z64);
        check({tag, ".xwe"}, 64'(xwe_o), Z64);
        check({tag, ".xsiz"}, 64'(xsiz_o), Z64);
        check({tag, ".xdat"}, xdat_o, Z64);
        check({tag, ".berr"}, 64'(berr_o), Z64);
        check({tag, ".iack"}, 64'(iack_o), Z64);
        check({tag, ".dack"}, 64'(dack_o), Z64);
    endtask

    initial begin
        vec[0] = '{T, F, F, 2'd0, A_I, Z64, Z64, F, Z64,         F, F, Z64, F, 2'd0, Z64, F, F};
        vec[1] = '{T, F, F, 2'd0, A_I, Z64, Z64, T, 64'h13,      T, T, A_I, F, 2'd2, Z64, T, F};
        vec[2] = '{F, T, T, 2'd3, Z64, A_D, W41, F, Z64,         F, F, Z64, F, 2'd0, Z64, F, F};
        vec[3] = '{F, T, T, 2'd3, Z64, A_D, W41, F, Z64,         T, T, A_D, T, 2'd3, W41, F, F};
        vec[4] = '{F, T, T, 2'd3, Z64, A_D, W41, F, Z64,         T, T, A_D, T, 2'd3, W41, F, F};
        vec[5] = '{F, T, T, 2'd3, Z64, A_D, W41, T, Z64,         T, T, A_D, T, 2'd3, W41, F, T};
        vec[6] = '{F, F, F, 2'd0, Z64, Z64, Z64, F, Z64,         F, F, Z64, F, 2'd0, Z64, F, F};
        vec[7] = '{F, T, F, 2'd1, Z64, A_R, W41, F, Z64,         F, F, Z64, F, 2'd0, Z64, F, F};
        vec[8] = '{F, T, F, 2'd1, Z64, A_R, W41, T, 64'hBEEF,    T, T, A_R, F, 2'd1, W41, F, T};
        vec[9] = '{F, F, F, 2'd0, Z64, Z64, Z64, F, Z64,         F, F, Z64, F, 2'd0, Z64, F, F};

        // Reset state, checked while reset is still held.
        reset_i = 1'b1;
        idle_inputs();
        step();
        step();
        #1;
        check_all_zero("reset");
        reset_i = 1'b0;

        // Table: single I fetch, D write with 2 wait states, D half read.
        for (int i = 0; i < 10; i++) begin
            istb_i = vec[i].istb;
            dstb_i = vec[i].dstb;
            dwe_i  = vec[i].dwe;
            dsiz_i = vec[i].dsiz;
            iadr_i = vec[i].iadr;
            dadr_i = vec[i].dadr;
            ddat_i = vec[i].ddat;
            xack_i = vec[i].xack;
            xdat_i = vec[i].xdat;
            #1;
            check($sformatf("v%0d.xstb", i), 64'(xstb_o), 64'(vec[i].e_xstb));
            if (vec[i].chk_x) begin
                check($sformatf("v%0d.xadr", i), xadr_o, vec[i].e_xadr);
                check($sformatf("v%0d.xwe", i), 64'(xwe_o), 64'(vec[i].e_xwe));
                check($sformatf("v%0d.xsiz", i), 64'(xsiz_o), 64'(vec[i].e_xsiz));
                check($sformatf("v%0d.xdat", i), xdat_o, vec[i].e_xdat);
            end
            check($sformatf("v%0d.iack", i), 64'(iack_o), 64'(vec[i].e_iack));
            check($sformatf("v%0d.dack", i), 64'(dack_o), 64'(vec[i].e_dack));
            check($sformatf("v%0d.idat", i), 64'(idat_o), 64'(vec[i].xdat[31:0]));
            check($sformatf("v%0d.ddat", i), ddat_o, vec[i].xdat);
            check($sformatf("v%0d.berr", i), 64'(berr_o), Z64);
            step();
        end

        // Saturation: both ports held, zero-wait slave -> I, D, I, D over 16 cycles.
        do_reset();
        istb_i = 1'b1;
        iadr_i = 64'h100;
        dstb_i = 1'b1;
        dadr_i = 64'h200;
        xack_i = 1'b1;
        begin
            int n_gnt;
            n_gnt = 0;
            for (int k = 0; k < 16; k++) begin
                #1;
                check($sformatf("sat%0d.iack", k), 64'(iack_o), 64'((k % 4) == 1));
                check($sformatf("sat%0d.dack", k), 64'(dack_o), 64'((k % 4) == 3));
                if (iack_o || dack_o) n_gnt++;
                step();
            end
            check("sat.count", 64'(n_gnt), 64'd8);
        end

        // Watchdog abort on a D read that is never acknowledged.
        do_reset();
        dstb_i = 1'b1;
        dadr_i = 64'h40;
        step();
        for (int k = 1; k <= 6; k++) begin
            #1;
            check($sformatf("tmo%0d.xstb", k), 64'(xstb_o), 64'(k <= 5));
            check($sformatf("tmo%0d.dack", k), 64'(dack_o), 64'(k == 6));
            check($sformatf("tmo%0d.berr", k), 64'(berr_o), 64'(k == 6));
            check($sformatf("tmo%0d.iack", k), 64'(iack_o), Z64);
            if (k == 6) check("tmo.ddat", ddat_o, 64'hFFFF_FFFF_FFFF_FFFF);
            step();
        end
        dstb_i = 1'b0;
        #1;
        check("tmo.after.berr", 64'(berr_o), Z64);
        check("tmo.after.dack", 64'(dack_o), Z64);
        step();

        // Ack on the same cycle the watchdog expires: ack wins.
        do_reset();
        istb_i = 1'b1;
        iadr_i = 64'h50;
        step();
        for (int k = 1; k <= 5; k++) begin
            xack_i = (k == 5);
            xdat_i = (k == 5) ? 64'h1234_5678_CAFE_F00D : Z64;
            #1;
            check($sformatf("race%0d.xstb", k), 64'(xstb_o), 64'd1);
            check($sformatf("race%0d.iack", k), 64'(iack_o), 64'(k == 5));
            if (k == 5) check("race.idat", 64'(idat_o), 64'hCAFE_F00D);
            step();
        end
        istb_i = 1'b0;
        xack_i = 1'b0;
        xdat_i = '0;
        #1;
        check("race.after.berr", 64'(berr_o), Z64);
        check("race.after.iack", 64'(iack_o), Z64);
        check("race.after.xstb", 64'(xstb_o), Z64);
        step();

        // Reset during GNT_D with the request still pending.
        do_reset();
        dstb_i = 1'b1;
        dwe_i  = 1'b1;
        dsiz_i = 2'd3;
        dadr_i = 64'h60;
        ddat_i = W41;
        step();
        #1;
        check("rst.gnt.xstb", 64'(xstb_o), 64'd1);
        reset_i = 1'b1;
        istb_i  = 1'b1;
        iadr_i  = 64'h70;
        step();
        reset_i = 1'b0;
        #1;
        check_all_zero("rst.mid");
        step();
        xack_i = 1'b1;
        #1;
        check("rst.first.xadr", xadr_o, 64'h70);
        check("rst.first.iack", 64'(iack_o), 64'd1);
        check("rst.first.dack", 64'(dack_o), Z64);
        step();
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
